// File: rtl/gpu_pkg.sv
// Shared GPU core encodings: scheduler core_state values, per-thread LSU state, bus width defaults.
// Pure declarations, no logic, no latency or backpressure of its own.
package gpu_pkg;

  localparam logic [2:0] CORE_IDLE    = 3'b000;
  localparam logic [2:0] CORE_FETCH   = 3'b001;
  localparam logic [2:0] CORE_DECODE  = 3'b010;
  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_WAIT    = 3'b100;
  localparam logic [2:0] CORE_EXECUTE = 3'b101;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;
  localparam logic [2:0] CORE_DONE    = 3'b111;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'b00,
    LSU_REQUESTING = 2'b01,
    LSU_WAITING    = 2'b10,
    LSU_DONE       = 2'b11
  } lsu_state_t;

  localparam int DEFAULT_ADDR_BITS = 8;
  localparam int DEFAULT_DATA_BITS = 8;

endpackage

// File: rtl/lsu_cluster_rr_arbiter.sv
// Round-robin pick of the first set req bit at or after ptr, wrapping N-1 -> 0.
// Combinational, zero latency; no backpressure (grant_any=0 when nothing requests).
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] grant_idx,
  output logic          grant_any
);

  logic [PW-1:0] idx;

  // Scan from the far end backwards so the candidate closest to ptr is the last one written.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end

endmodule

// File: rtl/lsu_cluster.sv
// Per-core load/store unit: captures each thread's LDR/STR on REQUEST and serialises them onto one memory channel.
// Grant one edge after REQUESTING, completion on the valid&ready edge; valid/address/data hold until ready.
module lsu_cluster
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int ADDR_BITS         = DEFAULT_ADDR_BITS,
  parameter int DATA_BITS         = DEFAULT_DATA_BITS
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [2:0]                             core_state,
  input  logic                                   decoded_mem_read_enable,
  input  logic                                   decoded_mem_write_enable,
  input  logic [THREADS_PER_BLOCK-1:0]           thread_enable,
  input  logic [THREADS_PER_BLOCK*ADDR_BITS-1:0] rs,
  input  logic [THREADS_PER_BLOCK*DATA_BITS-1:0] rt,
  output logic                                   mem_read_valid,
  output logic [ADDR_BITS-1:0]                   mem_read_address,
  input  logic                                   mem_read_ready,
  input  logic [DATA_BITS-1:0]                   mem_read_data,
  output logic                                   mem_write_valid,
  output logic [ADDR_BITS-1:0]                   mem_write_address,
  output logic [DATA_BITS-1:0]                   mem_write_data,
  input  logic                                   mem_write_ready,
  output logic [THREADS_PER_BLOCK*2-1:0]         lsu_state,
  output logic [THREADS_PER_BLOCK*DATA_BITS-1:0] lsu_out
);

  localparam int T  = THREADS_PER_BLOCK;
  localparam int PW = (T > 1) ? $clog2(T) : 1;

  lsu_state_t           st     [T];
  logic [T-1:0]         op_read;
  logic [ADDR_BITS-1:0] addr_q [T];
  logic [DATA_BITS-1:0] data_q [T];

  logic          busy;
  logic [PW-1:0] gnt_q;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] next_ptr;
  logic [PW-1:0] arb_idx;
  logic          arb_any;
  logic [T-1:0]  req_vec;
  logic          rd_done;
  logic          wr_done;
  logic          mem_op;

  always_comb begin
    req_vec = '0;
    for (int i = 0; i < T; i++) req_vec[i] = (st[i] == LSU_REQUESTING);
  end

  rr_arbiter #(.N(T)) u_arb (
    .req       (req_vec),
    .ptr       (rr_ptr),
    .grant_idx (arb_idx),
    .grant_any (arb_any)
  );

  for (genvar g = 0; g < T; g++) begin : g_state_out
    assign lsu_state[2*g +: 2] = st[g];
  end

  // A ready on the idle channel must never complete the other channel's transaction.
  assign rd_done  = mem_read_valid & mem_read_ready;
  assign wr_done  = mem_write_valid & mem_write_ready;
  assign mem_op   = decoded_mem_read_enable | decoded_mem_write_enable;
  assign next_ptr = (int'(gnt_q) == T - 1) ? '0 : gnt_q + PW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < T; i++) begin
        st[i]     <= LSU_IDLE;
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      op_read           <= '0;
      busy              <= 1'b0;
      gnt_q             <= '0;
      rr_ptr            <= '0;
      mem_read_valid    <= 1'b0;
      mem_read_address  <= '0;
      mem_write_valid   <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      lsu_out           <= '0;
    end else begin
      for (int i = 0; i < T; i++) begin
        if (core_state == CORE_REQUEST && thread_enable[i] && mem_op && st[i] == LSU_IDLE) begin
          st[i]      <= LSU_REQUESTING;
          op_read[i] <= decoded_mem_read_enable;
          addr_q[i]  <= rs[i*ADDR_BITS +: ADDR_BITS];
          data_q[i]  <= rt[i*DATA_BITS +: DATA_BITS];
        end
        if (core_state == CORE_UPDATE && st[i] == LSU_DONE) st[i] <= LSU_IDLE;
      end

      if (!busy && arb_any) begin
        st[arb_idx] <= LSU_WAITING;
        busy        <= 1'b1;
        gnt_q       <= arb_idx;
        if (op_read[arb_idx]) begin
          mem_read_valid   <= 1'b1;
          mem_read_address <= addr_q[arb_idx];
        end else begin
          mem_write_valid   <= 1'b1;
          mem_write_address <= addr_q[arb_idx];
          mem_write_data    <= data_q[arb_idx];
        end
      end

      // busy is still set on the completion edge, so a new grant waits for the following edge.
      if (busy && (rd_done || wr_done)) begin
        mem_read_valid  <= 1'b0;
        mem_write_valid <= 1'b0;
        busy            <= 1'b0;
        st[gnt_q]       <= LSU_DONE;
        rr_ptr          <= next_ptr;
        if (rd_done) lsu_out[gnt_q*DATA_BITS +: DATA_BITS] <= mem_read_data;
      end
    end
  end

endmodule

// File: tb/tb_lsu_cluster.sv
// Scoreboarded bench for lsu_cluster: directed LDR/STR sequences, expected memory requests queued by stimulus,
// checked by a memory-responder monitor that also enforces request hold and valid drop after ready.
module tb_lsu_cluster;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  core_state = 3'b000;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  thread_enable = 4'b0;
  logic [31:0] rs = '0;
  logic [31:0] rt = '0;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [7:0]  mem_read_data;
  logic        mem_write_valid;
  logic [7:0]  mem_write_address;
  logic [7:0]  mem_write_data;
  logic        mem_write_ready;
  logic [7:0]  lsu_state;
  logic [31:0] lsu_out;

  logic resp_rd = 1'b0;
  logic resp_wr = 1'b0;
  logic late_ready = 1'b0;

  // Memory contents are modelled as address ^ 8'hA5.
  assign mem_read_ready  = resp_rd | late_ready;
  assign mem_write_ready = resp_wr;
  assign mem_read_data   = mem_read_address ^ 8'hA5;

  always #5 clk = ~clk;

  lsu_cluster #(.THREADS_PER_BLOCK(4), .ADDR_BITS(8), .DATA_BITS(8)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .core_state               (core_state),
    .decoded_mem_read_enable  (rd_en),
    .decoded_mem_write_enable (wr_en),
    .thread_enable            (thread_enable),
    .rs                       (rs),
    .rt                       (rt),
    .mem_read_valid           (mem_read_valid),
    .mem_read_address         (mem_read_address),
    .mem_read_ready           (mem_read_ready),
    .mem_read_data            (mem_read_data),
    .mem_write_valid          (mem_write_valid),
    .mem_write_address        (mem_write_address),
    .mem_write_data           (mem_write_data),
    .mem_write_ready          (mem_write_ready),
    .lsu_state                (lsu_state),
    .lsu_out                  (lsu_out)
  );

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   resp_delay = 2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin : responder
    bit   busy_m;
    int   cnt;
    txn_t cap;
    txn_t e;
    busy_m = 1'b0;
    cnt    = 0;
    cap    = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_m  = 1'b0;
        resp_rd = 1'b0;
        resp_wr = 1'b0;
      end else if (resp_rd || resp_wr) begin
        resp_rd = 1'b0;
        resp_wr = 1'b0;
        busy_m  = 1'b0;
        chk("valid_drop", {30'b0, mem_read_valid, mem_write_valid}, 32'd0);
      end else if (busy_m) begin
        chk("hold_valid", cap.wr ? mem_write_valid : mem_read_valid, 1);
        chk("hold_addr", cap.wr ? mem_write_address : mem_read_address, cap.addr);
        if (cap.wr) chk("hold_data", mem_write_data, cap.data);
        cnt--;
        if (cnt <= 0) begin
          resp_rd = !cap.wr;
          resp_wr = cap.wr;
        end
      end else if (mem_read_valid || mem_write_valid) begin
        cap.wr   = mem_write_valid;
        cap.addr = mem_write_valid ? mem_write_address : mem_read_address;
        cap.data = mem_write_data;
        if (exp_q.size() == 0) begin
          chk("unexpected_req", {23'b0, cap.wr, cap.addr}, 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("req_both_valid", {31'b0, mem_read_valid & mem_write_valid}, 32'd0);
          chk("req_kind", cap.wr, e.wr);
          chk("req_addr", cap.addr, e.addr);
          if (e.wr) chk("req_data", cap.data, e.data);
        end
        busy_m = 1'b1;
        cnt    = resp_delay - 1;
        if (cnt <= 0) begin
          resp_rd = !cap.wr;
          resp_wr = cap.wr;
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input string name, input logic [7:0] mask, input logic [7:0] val);
    int k;
    k = 0;
    while (((lsu_state & mask) != val) && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(name, lsu_state & mask, val);
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [3:0] en,
                       input logic [31:0] a, input logic [31:0] d);
    core_state    = 3'b011;
    rd_en         = rd;
    wr_en         = wr;
    thread_enable = en;
    rs            = a;
    rt            = d;
    @(negedge clk);
    core_state = 3'b100;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
  endtask

  task automatic release_all();
    core_state = 3'b110;
    @(negedge clk);
    core_state = 3'b000;
  endtask

  task automatic push(input logic wr, input logic [7:0] addr, input logic [7:0] data);
    txn_t t;
    t.wr   = wr;
    t.addr = addr;
    t.data = data;
    exp_q.push_back(t);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    tick(3);
    reset = 1'b0;
    chk("rst_state", lsu_state, 0);
    chk("rst_valids", {mem_read_valid, mem_write_valid}, 0);
    chk("rst_addr", {mem_read_address, mem_write_address, mem_write_data}, 0);
    chk("rst_out", lsu_out, 0);

    // Four reads, pointer at 0: issue order 10,20,30,40.
    push(0, 8'd10, 8'h0); push(0, 8'd20, 8'h0); push(0, 8'd30, 8'h0); push(0, 8'd40, 8'h0);
    issue(1, 0, 4'hF, {8'd40, 8'd30, 8'd20, 8'd10}, 32'h0);
    wait_state("ld4_done", 8'hFF, 8'hFF);
    chk("ld4_out", lsu_out, 32'h8DBBB1AF);
    release_all();
    chk("update_idle", lsu_state, 0);

    // Stores on threads 0 and 2 only.
    push(1, 8'h33, 8'hC1); push(1, 8'h55, 8'hC3);
    issue(0, 1, 4'b0101, {8'h99, 8'h55, 8'h88, 8'h33}, {8'hEE, 8'hC3, 8'hDD, 8'hC1});
    for (int k = 0; k < 300 && ((lsu_state & 8'h33) != 8'h33); k++) begin
      chk("st_idle13", lsu_state & 8'hCC, 0);
      tick();
    end
    chk("st_done02", lsu_state, 8'h33);
    chk("st_out_kept", lsu_out, 32'h8DBBB1AF);
    release_all();
    chk("st_release", lsu_state, 0);

    // Neither load nor store.
    issue(0, 0, 4'hF, 32'h12345678, 32'h9ABCDEF0);
    for (int k = 0; k < 8; k++) begin
      chk("nomem_state", lsu_state, 0);
      chk("nomem_valid", {mem_read_valid, mem_write_valid}, 0);
      tick();
    end
    chk("nomem_out_kept", lsu_out, 32'h8DBBB1AF);
    release_all();

    // Thread 1 alone leaves the pointer at 2, then all four: order 2,3,0,1.
    push(0, 8'h61, 8'h0);
    issue(1, 0, 4'b0010, {8'h0, 8'h0, 8'h61, 8'h0}, 32'h0);
    wait_state("rr_pre_done", 8'h0C, 8'h0C);
    chk("rr_pre_out", lsu_out[15:8], 8'hC4);
    release_all();
    push(0, 8'h72, 8'h0); push(0, 8'h73, 8'h0); push(0, 8'h70, 8'h0); push(0, 8'h71, 8'h0);
    issue(1, 0, 4'hF, {8'h73, 8'h72, 8'h71, 8'h70}, 32'h0);
    wait_state("rr_done", 8'hFF, 8'hFF);
    chk("rr_out", lsu_out, 32'hD6D7D4D5);
    release_all();

    // Ready withheld for 5 cycles on thread 3.
    resp_delay = 6;
    push(0, 8'h90, 8'h0);
    issue(1, 0, 4'b1000, {8'h90, 24'h0}, 32'h0);
    wait_state("hold_waiting", 8'hC0, 8'h80);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_state", lsu_state & 8'hC0, 8'h80);
      chk("hold_rvalid", mem_read_valid, 1);
      chk("hold_raddr", mem_read_address, 8'h90);
    end
    wait_state("hold_done", 8'hC0, 8'hC0);
    chk("hold_valid_low", mem_read_valid, 0);
    chk("hold_out", lsu_out[31:24], 8'h35);
    release_all();
    resp_delay = 2;

    // Reset while thread 1 is WAITING, then a stray read ready.
    resp_delay = 100;
    push(0, 8'h44, 8'h0);
    issue(1, 0, 4'b0010, {16'h0, 8'h44, 8'h0}, 32'h0);
    wait_state("rst_waiting", 8'h0C, 8'h08);
    reset = 1'b1;
    tick();
    chk("rst_mid_valid", mem_read_valid, 0);
    chk("rst_mid_state", lsu_state, 0);
    tick();
    reset = 1'b0;
    late_ready = 1'b1;
    tick();
    late_ready = 1'b0;
    tick();
    chk("late_out", lsu_out, 0);
    chk("late_state", lsu_state, 0);
    chk("late_valid", {mem_read_valid, mem_write_valid}, 0);
    resp_delay = 2;

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
